// File: rtl/hough_edge_feeder.sv
// Edge-pixel feeder for a Hough accumulator: thresholds Sobel magnitudes in raster order,
// suppresses the image border and buffers edge coordinates in a FIFO with a valid/ready output.
module hough_edge_feeder #(
    parameter int IMG_WIDTH      = 640,
    parameter int IMG_HEIGHT     = 480,
    parameter int MAG_BITS       = 8,
    parameter int EDGE_THRESHOLD = 64,
    parameter int FIFO_DEPTH     = 64,
    parameter int MAX_EDGES      = 4095
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [MAG_BITS-1:0] mag_in,
    input  logic                mag_valid,
    input  logic                sof_in,
    input  logic                out_ready,
    output logic                pixel_in,
    output logic                pixel_valid,
    output logic [9:0]          pixel_x,
    output logic [9:0]          pixel_y,
    output logic                frame_start,
    output logic                frame_done,
    output logic [11:0]         edge_count,
    output logic [15:0]         drop_count
);
    localparam int                  AW       = $clog2(FIFO_DEPTH);
    localparam logic [9:0]          X_LAST   = 10'(IMG_WIDTH - 1);
    localparam logic [9:0]          Y_LAST   = 10'(IMG_HEIGHT - 1);
    localparam logic [MAG_BITS-1:0] THR      = MAG_BITS'(EDGE_THRESHOLD);
    localparam logic [11:0]         EDGE_MAX = 12'(MAX_EDGES);
    localparam logic [AW:0]         FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

    state_t        state;
    logic [9:0]    x, y;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [19:0]   mem [FIFO_DEPTH];

    logic       sof, take, interior, qualify, pop, do_push, drop, last_px;
    logic [9:0] cur_x, cur_y;

    // cur_x/cur_y is the position of the pixel on mag_in this cycle; x/y hold the next one.
    always_comb begin
        sof      = mag_valid && sof_in;
        take     = sof || (mag_valid && state == ACTIVE);
        cur_x    = sof ? '0 : x;
        cur_y    = sof ? '0 : y;
        interior = (cur_x != '0) && (cur_x != X_LAST) && (cur_y != '0) && (cur_y != Y_LAST);
        qualify  = take && (mag_in >= THR) && interior;
        pop      = (count != '0) && out_ready;
        do_push  = qualify && (edge_count != EDGE_MAX) && ((count != FULL_CNT) || pop);
        drop     = qualify && !do_push;
        last_px  = take && (cur_x == X_LAST) && (cur_y == Y_LAST);
    end

    assign pixel_valid      = (count != '0);
    assign pixel_in         = pixel_valid;
    assign {pixel_x, pixel_y} = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x           <= '0;
            y           <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            edge_count  <= '0;
            drop_count  <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            if (take) begin
                if (cur_x == X_LAST) begin
                    x <= '0;
                    y <= (cur_y == Y_LAST) ? cur_y : cur_y + 1'b1;
                end else begin
                    x <= cur_x + 1'b1;
                    y <= cur_y;
                end
            end
            // Resync flushes the backlog silently; the sof pixel itself is never pushed.
            if (sof) begin
                state       <= ACTIVE;
                wr_ptr      <= '0;
                rd_ptr      <= '0;
                count       <= '0;
                edge_count  <= '0;
                drop_count  <= '0;
                frame_start <= 1'b1;
                frame_done  <= 1'b0;
            end else begin
                frame_start <= 1'b0;
                frame_done  <= 1'b0;
                if (do_push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)     rd_ptr <= rd_ptr + 1'b1;
                case ({do_push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
                if (do_push) edge_count <= edge_count + 1'b1;
                if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 1'b1;
                case (state)
                    ACTIVE:  if (last_px) state <= DRAIN;
                    DRAIN:   if (count == '0) begin
                                 state      <= IDLE;
                                 frame_done <= 1'b1;
                             end
                    default: state <= state;
                endcase
            end
        end
    end

    // Storage is reset so the head registers read zero during and after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (do_push) begin
            mem[wr_ptr] <= {cur_x, cur_y};
        end
    end
endmodule

// File: tb/tb_hough_edge_feeder.sv
// Directed bench for hough_edge_feeder on a reduced 16x8 image with an 8-deep FIFO and a 20-edge cap.
module tb_hough_edge_feeder;
    localparam int W = 16;
    localparam int H = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] mag_in;
    logic       mag_valid, sof_in, out_ready;
    logic       pixel_in, pixel_valid, frame_start, frame_done;
    logic [9:0] pixel_x, pixel_y;
    logic [11:0] edge_count;
    logic [15:0] drop_count;

    int total  = 0;
    int passed = 0;
    int starts;

    hough_edge_feeder #(
        .IMG_WIDTH(W), .IMG_HEIGHT(H), .MAG_BITS(8), .EDGE_THRESHOLD(64),
        .FIFO_DEPTH(8), .MAX_EDGES(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .mag_in(mag_in), .mag_valid(mag_valid), .sof_in(sof_in),
        .out_ready(out_ready), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .frame_start(frame_start),
        .frame_done(frame_done), .edge_count(edge_count), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    endtask

    task automatic px(input logic [7:0] m, input logic s);
        mag_in = m; sof_in = s; mag_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        mag_in = '0; sof_in = 1'b0; mag_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic [7:0] mag_a(int x);
        if (x == 5) return 8'd200;
        if (x == 7) return 8'd63;
        if (x == 9) return 8'd64;
        if (x == 0 || x == W - 1) return 8'd255;
        return 8'd0;
    endfunction

    initial begin
        rst_n = 1'b0; mag_in = '0; mag_valid = 1'b0; sof_in = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(pixel_valid), 0);
        chk("rst_pixel_in", 32'(pixel_in), 0);
        chk("rst_fstart", 32'(frame_start), 0);
        chk("rst_fdone", 32'(frame_done), 0);
        chk("rst_x", 32'(pixel_x), 0);
        chk("rst_y", 32'(pixel_y), 0);
        chk("rst_edges", 32'(edge_count), 0);
        chk("rst_drops", 32'(drop_count), 0);
        rst_n = 1'b1;

        // IDLE ignores pixels without sof
        for (int i = 0; i < 3; i++) px(8'd255, 1'b0);
        chk("idle_valid", 32'(pixel_valid), 0);
        chk("idle_edges", 32'(edge_count), 0);

        // Frame A: column 5 strong, 7 just under threshold, 9 at threshold, borders strong
        starts = 0;
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                px(mag_a(x), (x == 0 && y == 0));
                if (frame_start) starts++;
                chk($sformatf("A_valid_%0d_%0d", x, y), 32'(pixel_valid),
                    32'((x == 5 || x == 9) && y >= 1 && y <= H - 2));
                if ((x == 5 || x == 9) && y >= 1 && y <= H - 2) begin
                    chk("A_x", 32'(pixel_x), 32'(x));
                    chk("A_y", 32'(pixel_y), 32'(y));
                end
            end
        end
        chk("A_starts", 32'(starts), 1);
        chk("A_fdone_early", 32'(frame_done), 0);
        idle();
        chk("A_fdone", 32'(frame_done), 1);
        idle();
        chk("A_fdone_pulse", 32'(frame_done), 0);
        chk("A_edges", 32'(edge_count), 12);
        chk("A_drops", 32'(drop_count), 0);

        // Frame B: stalled row fills the FIFO, then pass-through on full, then the cap
        out_ready = 1'b0;
        px(8'd0, 1'b1);
        for (int i = 1; i < 3 * W; i++) px(8'd0, 1'b0);
        for (int x = 0; x < W; x++) begin
            px(8'd255, 1'b0);
            if (x >= 1) begin
                chk("B_hold_valid", 32'(pixel_valid), 1);
                chk("B_hold_x", 32'(pixel_x), 1);
                chk("B_hold_y", 32'(pixel_y), 3);
            end
        end
        chk("B_edges_row3", 32'(edge_count), 8);
        chk("B_drops_row3", 32'(drop_count), 6);
        px(8'd255, 1'b0);
        out_ready = 1'b1;
        px(8'd255, 1'b0);
        chk("B_pass_drops", 32'(drop_count), 6);
        chk("B_pass_edges", 32'(edge_count), 9);
        chk("B_pass_x", 32'(pixel_x), 2);
        chk("B_pass_y", 32'(pixel_y), 3);
        for (int x = 2; x <= 12; x++) px(8'd255, 1'b0);
        chk("B_head_x", 32'(pixel_x), 5);
        chk("B_head_y", 32'(pixel_y), 4);
        out_ready = 1'b0;
        for (int x = 13; x < W; x++) px(8'd255, 1'b0);
        chk("B_cap_edges", 32'(edge_count), 20);
        chk("B_cap_drops", 32'(drop_count), 8);
        chk("B_backlog", 32'(pixel_valid), 1);

        // Resync at (10,5) with a full backlog
        for (int x = 0; x < 10; x++) px(8'd0, 1'b0);
        px(8'd255, 1'b1);
        chk("R_flush", 32'(pixel_valid), 0);
        chk("R_fstart", 32'(frame_start), 1);
        chk("R_edges", 32'(edge_count), 0);
        chk("R_drops", 32'(drop_count), 0);
        out_ready = 1'b1;
        px(8'd0, 1'b0);
        chk("R_fstart_pulse", 32'(frame_start), 0);
        for (int i = 2; i < W + 3; i++) begin
            px(8'd0, 1'b0);
            chk("R_no_old", 32'(pixel_valid), 0);
        end
        px(8'd255, 1'b0);
        chk("R_new_valid", 32'(pixel_valid), 1);
        chk("R_new_x", 32'(pixel_x), 3);
        chk("R_new_y", 32'(pixel_y), 1);
        out_ready = 1'b0;
        px(8'd255, 1'b0);
        chk("R_edges2", 32'(edge_count), 2);

        // Reset while a coordinate is pending
        rst_n = 1'b0;
        #2;
        chk("X_valid", 32'(pixel_valid), 0);
        chk("X_pixel_in", 32'(pixel_in), 0);
        chk("X_x", 32'(pixel_x), 0);
        chk("X_y", 32'(pixel_y), 0);
        chk("X_edges", 32'(edge_count), 0);
        chk("X_fstart", 32'(frame_start), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            px(8'd255, 1'b0);
            chk("X_post_valid", 32'(pixel_valid), 0);
            chk("X_post_fstart", 32'(frame_start), 0);
        end
        chk("X_post_edges", 32'(edge_count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
